// File: rtl/dmem_sram_ctrl.sv
// dmem_sram_ctrl: bridges the MEM-stage dmem_* request bundle to a single-port,
// word-wide synchronous SRAM with one-cycle read latency and no byte enables.
// Sub-word stores are done as read-modify-write. Loads get lane extraction and
// sign/zero extension. The pipeline is stalled for the one extra cycle that
// loads and sub-word stores need.
//
// Ports
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   dmem_valid         request present
//   dmem_addr          byte address
//   dmem_writeData     right-aligned store data
//   dmem_memRead/Write load / store request (store wins if both are set)
//   dmem_maskMode      0 byte, 1 half, 2 word, 3 treated as word
//   dmem_sext          sign-extend load result
//   dmem_readData      formatted load result (valid with dmem_done)
//   dmem_done          access-complete pulse
//   dmem_stall         hold request inputs stable
//   dmem_misalign      misaligned-request-rejected pulse
//   sram_*             SRAM access port; sram_rdata is valid one cycle after a read
module dmem_sram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dmem_valid,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_writeData,
    input  logic                  dmem_memRead,
    input  logic                  dmem_memWrite,
    input  logic [1:0]            dmem_maskMode,
    input  logic                  dmem_sext,
    output logic [31:0]           dmem_readData,
    output logic                  dmem_done,
    output logic                  dmem_stall,
    output logic                  dmem_misalign,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [1:0] {StIdle, StLoad, StMerge} state_t;

    state_t state_q, state_d;

    // Held copy of the request while a two-cycle access is in flight.
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]            hoff_q, hoff_d;
    logic [1:0]            hmode_q, hmode_d;
    logic                  hsext_q, hsext_d;
    logic [15:0]           hwdata_q, hwdata_d;

    logic [31:0] rdata_q, rdata_d;

    // Pre-reset-gating versions of the outputs.
    logic                  en_c, we_c, done_c, stall_c, mis_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [31:0]           wdata_c, rd_c;

    logic req, misaligned;
    logic unused_addr;

    // Address bits above the SRAM word address are ignored (addresses wrap).
    assign unused_addr = ^dmem_addr[31:ADDR_WIDTH+2];

    assign req = dmem_valid & (dmem_memRead | dmem_memWrite);
    assign misaligned = ((dmem_maskMode == 2'd1) & dmem_addr[0]) |
                        (dmem_maskMode[1] & (dmem_addr[1:0] != 2'b00));

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] mode, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (mode)
            2'd0:    fmt_load = {{24{sext & b[7]}}, b};
            2'd1:    fmt_load = {{16{sext & h[15]}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] mode, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (mode == 2'd0) begin
            r[{off, 3'b000} +: 8] = d[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = d;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hoff_d   = hoff_q;
        hmode_d  = hmode_q;
        hsext_d  = hsext_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        en_c     = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;
        done_c   = 1'b0;
        stall_c  = 1'b0;
        mis_c    = 1'b0;
        rd_c     = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (misaligned) begin
                        mis_c  = 1'b1;
                        done_c = 1'b1;
                        rd_c   = '0;
                    end else if (dmem_memWrite && dmem_maskMode[1]) begin
                        en_c    = 1'b1;
                        we_c    = 1'b1;
                        addr_c  = dmem_addr[ADDR_WIDTH+1:2];
                        wdata_c = dmem_writeData;
                        done_c  = 1'b1;
                        rd_c    = '0;
                    end else begin
                        // Loads and sub-word stores both start with an SRAM read.
                        en_c     = 1'b1;
                        addr_c   = dmem_addr[ADDR_WIDTH+1:2];
                        stall_c  = 1'b1;
                        haddr_d  = dmem_addr[ADDR_WIDTH+1:2];
                        hoff_d   = dmem_addr[1:0];
                        hmode_d  = dmem_maskMode;
                        hsext_d  = dmem_sext;
                        hwdata_d = dmem_writeData[15:0];
                        state_d  = dmem_memWrite ? StMerge : StLoad;
                    end
                end
            end
            StLoad: begin
                rd_c    = fmt_load(sram_rdata, hoff_q, hmode_q, hsext_q);
                rdata_d = rd_c;
                done_c  = 1'b1;
                state_d = StIdle;
            end
            StMerge: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = haddr_q;
                wdata_c = merge_lane(sram_rdata, hoff_q, hmode_q, hwdata_q);
                done_c  = 1'b1;
                rd_c    = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset forces every output low immediately, so an RMW caught in MERGE
    // never reaches the SRAM.
    always_comb begin
        sram_en       = reset & en_c;
        sram_we       = reset & we_c;
        sram_addr     = reset ? addr_c : '0;
        sram_wdata    = reset ? wdata_c : '0;
        dmem_done     = reset & done_c;
        dmem_stall    = reset & stall_c;
        dmem_misalign = reset & mis_c;
        dmem_readData = reset ? rd_c : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    if (INIT_ZERO) begin : g_held_rst
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                haddr_q  <= '0;
                hoff_q   <= '0;
                hmode_q  <= '0;
                hsext_q  <= 1'b0;
                hwdata_q <= '0;
            end else begin
                haddr_q  <= haddr_d;
                hoff_q   <= hoff_d;
                hmode_q  <= hmode_d;
                hsext_q  <= hsext_d;
                hwdata_q <= hwdata_d;
            end
        end
    end else begin : g_held_norst
        always_ff @(posedge clk) begin
            haddr_q  <= haddr_d;
            hoff_q   <= hoff_d;
            hmode_q  <= hmode_d;
            hsext_q  <= hsext_d;
            hwdata_q <= hwdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
module tb_dmem_sram_ctrl;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          dmem_valid;
    logic [31:0]   dmem_addr;
    logic [31:0]   dmem_writeData;
    logic          dmem_memRead;
    logic          dmem_memWrite;
    logic [1:0]    dmem_maskMode;
    logic          dmem_sext;
    logic [31:0]   dmem_readData;
    logic          dmem_done;
    logic          dmem_stall;
    logic          dmem_misalign;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    dmem_sram_ctrl #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_valid     (dmem_valid),
        .dmem_addr      (dmem_addr),
        .dmem_writeData (dmem_writeData),
        .dmem_memRead   (dmem_memRead),
        .dmem_memWrite  (dmem_memWrite),
        .dmem_maskMode  (dmem_maskMode),
        .dmem_sext      (dmem_sext),
        .dmem_readData  (dmem_readData),
        .dmem_done      (dmem_done),
        .dmem_stall     (dmem_stall),
        .dmem_misalign  (dmem_misalign),
        .sram_en        (sram_en),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model, one-cycle read latency.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic        en;
        logic [3:0]  stalls;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] mode, input logic sext);
        dmem_valid     = 1'b1;
        dmem_memRead   = rd;
        dmem_memWrite  = wr;
        dmem_addr      = addr;
        dmem_writeData = wd;
        dmem_maskMode  = mode;
        dmem_sext      = sext;
    endtask

    task automatic idle();
        dmem_valid    = 1'b0;
        dmem_memRead  = 1'b0;
        dmem_memWrite = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] rd, input logic mis,
                        input logic en, input int stalls);
        exp_t e;
        e.rd = rd; e.mis = mis; e.en = en; e.stalls = 4'(stalls);
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Waits (bounded) for dmem_done, then pops and checks the scoreboard entry.
    task automatic wait_done();
        int   stalls = 0;
        bit   seen = 1'b0;
        exp_t e;
        string t;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (dmem_done) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    t = tag_q.pop_front();
                    check({t, "_rdata"}, dmem_readData, e.rd);
                    check({t, "_misalign"}, {31'd0, dmem_misalign}, {31'd0, e.mis});
                    check({t, "_sram_en"}, {31'd0, sram_en}, {31'd0, e.en});
                    check({t, "_stall_at_done"}, {31'd0, dmem_stall}, 32'd0);
                    check({t, "_stall_cycles"}, stalls, {28'd0, e.stalls});
                end
            end else if (dmem_stall) begin
                stalls++;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] mode,
                      input logic sext, input logic [31:0] exp_rd, input logic exp_mis,
                      input logic exp_en, input int exp_stalls);
        drive(rd, wr, addr, wd, mode, sext);
        push(tag, exp_rd, exp_mis, exp_en, exp_stalls);
        wait_done();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b0;
        dmem_valid = 1'b0; dmem_memRead = 1'b0; dmem_memWrite = 1'b0;
        dmem_addr = '0; dmem_writeData = '0; dmem_maskMode = '0; dmem_sext = 1'b0;
        #12;
        check("reset_done", {31'd0, dmem_done}, 32'd0);
        check("reset_stall", {31'd0, dmem_stall}, 32'd0);
        check("reset_sram_en", {31'd0, sram_en}, 32'd0);
        check("reset_rdata", dmem_readData, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Word store / load round trip.
        op("sw_100", 1'b0, 1'b1, 32'h100, 32'h11223344, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        check("mem_40_sw", mem[12'h040], 32'h11223344);
        op("lw_100", 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h11223344, 1'b0, 1'b0, 1);

        // Byte RMW; upper writeData bits must not leak into the word.
        op("sb_101", 1'b0, 1'b1, 32'h101, 32'hFFFFFFAB, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("mem_40_sb", mem[12'h040], 32'h1122AB44);

        // Lane extraction and extension.
        op("sw_200", 1'b0, 1'b1, 32'h200, 32'h80010080, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        op("lb_200", 1'b1, 1'b0, 32'h200, 32'h0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 1);
        op("lbu_200", 1'b1, 1'b0, 32'h200, 32'h0, 2'd0, 1'b0, 32'h00000080, 1'b0, 1'b0, 1);
        op("lh_202", 1'b1, 1'b0, 32'h202, 32'h0, 2'd1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 1);
        op("lhu_202", 1'b1, 1'b0, 32'h202, 32'h0, 2'd1, 1'b0, 32'h00008001, 1'b0, 1'b0, 1);
        op("lb_203", 1'b1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 1);
        op("lbu_201", 1'b1, 1'b0, 32'h201, 32'h0, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1);

        // Misaligned requests are rejected without touching the SRAM.
        op("lw_102_mis", 1'b1, 1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        op("sh_103_mis", 1'b0, 1'b1, 32'h103, 32'hBEEF, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0, 0);
        check("mem_40_mis", mem[12'h040], 32'h1122AB44);

        // Half RMW on the upper lane, then a wrapped-address load of the same word.
        op("sh_102", 1'b0, 1'b1, 32'h102, 32'h00001234, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        check("mem_40_sh", mem[12'h040], 32'h1234AB44);
        op("lw_4100_wrap", 1'b1, 1'b0, 32'h4100, 32'h0, 2'd2, 1'b0, 32'h1234AB44, 1'b0, 1'b0, 1);

        // Reset in the MERGE cycle abandons the write.
        op("sw_300", 1'b0, 1'b1, 32'h300, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 0);
        drive(1'b0, 1'b1, 32'h302, 32'h0000BEEF, 2'd1, 1'b0);
        @(negedge clk);
        check("sh_302_issue_stall", {31'd0, dmem_stall}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_merge_sram_en", {31'd0, sram_en}, 32'd0);
        check("rst_merge_sram_we", {31'd0, sram_we}, 32'd0);
        check("rst_merge_done", {31'd0, dmem_done}, 32'd0);
        check("rst_merge_stall", {31'd0, dmem_stall}, 32'd0);
        check("rst_merge_wdata", sram_wdata, 32'd0);
        check("rst_merge_rdata", dmem_readData, 32'd0);
        @(posedge clk);
        #1;
        idle();
        reset = 1'b1;
        check("mem_c0_after_rst", mem[12'h0C0], 32'h0);
        op("lw_300_after_rst", 1'b1, 1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 1);

        // Back-to-back: word store held on the inputs while the load is in LOAD.
        drive(1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
        push("b2b_lw", 32'h80010080, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("b2b_lw_stall", {31'd0, dmem_stall}, 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 2'd2, 1'b0);
        push("b2b_sw", 32'h0, 1'b0, 1'b1, 0);
        wait_done();
        @(posedge clk);
        #1;
        wait_done();
        @(posedge clk);
        #1;
        idle();
        check("mem_81_b2b", mem[12'h081], 32'hCAFEF00D);
        check("mem_80_b2b", mem[12'h080], 32'h80010080);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
